// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, runs one
// operation at a time through the ALU and holds the response until consumed.
module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_control,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_control,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic [7:0]  resp_status,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_operand_1,
  output logic [31:0] alu_operand_2,
  input  logic [31:0] alu_result,
  input  logic [7:0]  alu_status,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic        prio_reg, prio_next;   // 1 = requester 1 wins the next tie
  logic        owner_reg;
  logic [3:0]  ctrl_reg;
  logic [31:0] op1_reg, op2_reg;
  logic [31:0] result_reg;
  logic [7:0]  status_reg;

  logic [1:0]  req_valid, grant, resp_ready_vec, resp_valid_vec;
  logic [3:0]  req_control [2];
  logic [31:0] req_op1 [2];
  logic [31:0] req_op2 [2];
  logic        accept, accept_id, accept_legal;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: is_legal = 1'b1;
      default:                                              is_legal = 1'b0;
    endcase
  endfunction

  assign req_valid      = {req1_valid, req0_valid};
  assign resp_ready_vec = {resp1_ready, resp0_ready};
  assign req_control[0] = req0_control;
  assign req_control[1] = req1_control;
  assign req_op1[0]     = req0_op1;
  assign req_op1[1]     = req1_op1;
  assign req_op2[0]     = req0_op2;
  assign req_op2[1]     = req1_op2;

  // Reset masks the grant so nothing is accepted in a reset cycle.
  always_comb begin
    grant = 2'b00;
    if (state_reg == IDLE && !rst) begin
      if (FAIR != 0) begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
          default: grant = 2'b00;
        endcase
      end else begin
        if (req_valid[0])      grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
      end
    end
  end

  assign accept       = |grant;
  assign accept_id    = grant[1];
  assign accept_legal = is_legal(req_control[accept_id]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign resp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign resp0_valid = resp_valid_vec[0];
  assign resp1_valid = resp_valid_vec[1];

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = accept_legal ? EXEC : RESP;
          prio_next  = ~accept_id;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready_vec[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      ctrl_reg   <= 4'b0000;
      op1_reg    <= 32'h0;
      op2_reg    <= 32'h0;
      result_reg <= 32'h0;
      status_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      if (accept) begin
        owner_reg <= accept_id;
        ctrl_reg  <= req_control[accept_id];
        op1_reg   <= req_op1[accept_id];
        op2_reg   <= req_op2[accept_id];
        if (!accept_legal) begin
          result_reg <= 32'h0;
          status_reg <= 8'h01;
        end
      end
      // Low two status bits are owned by the arbiter (illegal_op), not the ALU.
      if (state_reg == EXEC) begin
        result_reg <= alu_result;
        status_reg <= alu_status & 8'hFC;
      end
    end
  end

  assign alu_control   = (state_reg == EXEC) ? ctrl_reg : 4'b0000;
  assign alu_operand_1 = (state_reg == EXEC) ? op1_reg  : 32'h0;
  assign alu_operand_2 = (state_reg == EXEC) ? op2_reg  : 32'h0;
  assign resp_result   = result_reg;
  assign resp_status   = status_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance
// share request stimulus, each driven by its own behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [3:0]  req0_control, req1_control;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [31:0] resp_result, alu_operand_1, alu_operand_2, alu_result;
  logic [7:0]  resp_status, alu_status;
  logic [3:0]  alu_control;

  logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid, f_busy;
  logic [31:0] f_resp_result, f_alu_operand_1, f_alu_operand_2, f_alu_result;
  logic [7:0]  f_resp_status, f_alu_status;
  logic [3:0]  f_alu_control;

  int checks = 0;
  int errors = 0;

  function automatic logic [39:0] alu_model(input logic [3:0] ctrl, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = 33'h0; r = 32'h0; c = 1'b0; v = 1'b0;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), v, c, r[31], 4'b0000, r};
  endfunction

  assign {alu_status, alu_result}     = alu_model(alu_control, alu_operand_1, alu_operand_2);
  assign {f_alu_status, f_alu_result} = alu_model(f_alu_control, f_alu_operand_1, f_alu_operand_2);

  alu_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_status(resp_status),
    .alu_control(alu_control), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_status(alu_status), .busy(busy)
  );

  alu_arbiter #(.FAIR(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_control(req0_control),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_control(req1_control),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(f_resp_result), .resp_status(f_resp_status),
    .alu_control(f_alu_control), .alu_operand_1(f_alu_operand_1), .alu_operand_2(f_alu_operand_2),
    .alu_result(f_alu_result), .alu_status(f_alu_status), .busy(f_busy)
  );

  task automatic rst_all();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req1_ready, req0_ready}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({resp1_valid, resp0_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", {resp1_valid, resp0_valid}); end
    checks++; if (resp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", resp_result); end
    checks++; if (resp_status !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", resp_status); end
    checks++; if (alu_control !== 4'b0000) begin errors++; $display("FAIL reset_alu_control got %b exp 0000", alu_control); end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_single_add();
    @(negedge clk);
    req0_valid = 1'b1; req0_control = 4'b0010; req0_op1 = 32'h7FFF_FFFF; req0_op2 = 32'h1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL add_grant got %b exp 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_exec_busy got %b exp 1", busy); end
    checks++; if (alu_control !== 4'b0010) begin errors++; $display("FAIL add_alu_control got %b exp 0010", alu_control); end
    checks++; if (alu_operand_1 !== 32'h7FFF_FFFF || alu_operand_2 !== 32'h1) begin errors++; $display("FAIL add_operands got %h %h exp 7fffffff 00000001", alu_operand_1, alu_operand_2); end
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL add_early_resp got %b exp 0", resp0_valid); end
    @(negedge clk); #1;
    checks++; if ({resp1_valid, resp0_valid} !== 2'b01) begin errors++; $display("FAIL add_resp_valid got %b exp 01", {resp1_valid, resp0_valid}); end
    checks++; if (resp_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h exp 80000000", resp_result); end
    checks++; if (resp_status !== 8'h50) begin errors++; $display("FAIL add_status got %h exp 50", resp_status); end
    checks++; if (alu_control !== 4'b0000) begin errors++; $display("FAIL add_alu_idle got %b exp 0000", alu_control); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || resp0_valid !== 1'b0) begin errors++; $display("FAIL add_return_idle got busy %b valid %b exp 0 0", busy, resp0_valid); end
    $display("txn add req0 7fffffff+1 result %h status %h", 32'h8000_0000, 8'h50);
  endtask

  task automatic test_contention();
    int ng;
    int last;
    logic [1:0] exp_grant;
    logic [1:0] owner;
    ng = 0; last = 0; owner = 2'b00;
    rst_all();
    req0_valid = 1'b1; req0_control = 4'b0110; req0_op1 = 32'd5; req0_op2 = 32'd5;
    req1_valid = 1'b1; req1_control = 4'b0110; req1_op1 = 32'd5; req1_op2 = 32'd5;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (resp0_valid || resp1_valid) begin
        checks++; if ({resp1_valid, resp0_valid} !== owner) begin errors++; $display("FAIL cont_resp_owner got %b exp %b", {resp1_valid, resp0_valid}, owner); end
        checks++; if (resp_result !== 32'h0 || resp_status !== 8'h80) begin errors++; $display("FAIL cont_resp got %h/%h exp 00000000/80", resp_result, resp_status); end
      end
      if (req0_ready || req1_ready) begin
        exp_grant = (ng % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if ({req1_ready, req0_ready} !== exp_grant) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", ng, {req1_ready, req0_ready}, exp_grant); end
        if (ng > 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL cont_spacing got %0d exp 3", c - last); end
        end
        $display("txn contention grant %0d to req%0d", ng, exp_grant[1]);
        owner = {req1_ready, req0_ready};
        last = c; ng++;
      end
      @(negedge clk);
    end
    checks++; if (ng !== 4) begin errors++; $display("FAIL cont_grant_count got %0d exp 4", ng); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    req1_valid = 1'b1; req1_control = 4'b0011; req1_op1 = 32'hDEAD; req1_op2 = 32'hBEEF;
    resp1_ready = 1'b1; #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL ill_grant got %b exp 10", {req1_ready, req0_ready}); end
    @(negedge clk);
    req1_valid = 1'b0; #1;
    checks++; if ({resp1_valid, resp0_valid} !== 2'b10) begin errors++; $display("FAIL ill_resp_valid got %b exp 10", {resp1_valid, resp0_valid}); end
    checks++; if (resp_result !== 32'h0 || resp_status !== 8'h01) begin errors++; $display("FAIL ill_resp got %h/%h exp 00000000/01", resp_result, resp_status); end
    checks++; if (alu_control !== 4'b0000 || alu_operand_1 !== 32'h0) begin errors++; $display("FAIL ill_alu got %b/%h exp 0000/0", alu_control, alu_operand_1); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || alu_control !== 4'b0000) begin errors++; $display("FAIL ill_after got busy %b ctl %b exp 0 0000", busy, alu_control); end
    $display("txn illegal req1 op 0011 result 0 status 01");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_control = 4'b0001; req0_op1 = 32'hF0; req0_op2 = 32'h0F;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_grant got %b exp 1", req0_ready); end
    @(negedge clk);
    req1_valid = 1'b1; req1_control = 4'b0000; #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_exec_ready got %b exp 00", {req1_ready, req0_ready}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (resp0_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got valid %b busy %b exp 1 1", i, resp0_valid, busy); end
      checks++; if (resp_result !== 32'hFF || resp_status !== 8'h00) begin errors++; $display("FAIL bp_data%0d got %h/%h exp 000000ff/00", i, resp_result, resp_status); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, {req1_ready, req0_ready}); end
    end
    resp0_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || resp0_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy %b valid %b exp 0 0", busy, resp0_valid); end
    $display("txn backpressure req0 or result ff held 5 cycles");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req0_valid = 1'b1; req0_control = 4'b0010; req0_op1 = 32'd3; req0_op2 = 32'd4; #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmo_grant got %b exp 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmo_exec got busy %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || {resp1_valid, resp0_valid} !== 2'b00) begin errors++; $display("FAIL rmo_after_rst got busy %b valid %b exp 0 00", busy, {resp1_valid, resp0_valid}); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || {resp1_valid, resp0_valid} !== 2'b00 || resp_result !== 32'h0) begin errors++; $display("FAIL rmo_no_resp got busy %b valid %b result %h exp 0 00 0", busy, {resp1_valid, resp0_valid}, resp_result); end
    req0_valid = 1'b1; req0_control = 4'b0110; req0_op1 = 32'd5; req0_op2 = 32'd5;
    req1_valid = 1'b1; req1_control = 4'b0110; req1_op1 = 32'd5; req1_op2 = 32'd5;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rmo_first_grant got %b exp 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn reset mid-op dropped, next grant req0");
  endtask

  task automatic test_fixed_priority();
    int g0;
    g0 = 0;
    rst_all();
    req0_valid = 1'b1; req0_control = 4'b0110; req0_op1 = 32'd9; req0_op2 = 32'd2;
    req1_valid = 1'b1; req1_control = 4'b0110; req1_op1 = 32'd9; req1_op2 = 32'd2;
    for (int c = 0; c < 15; c++) begin
      #1;
      checks++; if (f_req1_ready !== 1'b0) begin errors++; $display("FAIL fix_req1_granted cycle %0d got 1 exp 0", c); end
      if (f_req0_ready) g0++;
      @(negedge clk);
    end
    checks++; if (g0 !== 5) begin errors++; $display("FAIL fix_req0_grants got %0d exp 5", g0); end
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!f_busy) break;
      @(negedge clk);
    end
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL fix_idle_timeout got busy %b exp 0", f_busy); end
    req0_valid = 1'b0; #1;
    checks++; if ({f_req1_ready, f_req0_ready} !== 2'b10) begin errors++; $display("FAIL fix_req1_turn got %b exp 10", {f_req1_ready, f_req0_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn fixed priority req0 grants %0d then req1", g0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_control = 4'b0000; req1_control = 4'b0000;
    req0_op1 = 32'h0; req0_op2 = 32'h0; req1_op1 = 32'h0; req1_op2 = 32'h0;
    test_reset();
    test_single_add();
    test_contention();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_fixed_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) operation accepted this cycle when reqN_valid & reqN_ready.
REQ-006 reqN_control  input  4  (N=0,1) ALU opcode: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor.
REQ-007 reqN_op1, reqN_op2  input  32  (N=0,1) operands.
REQ-008 respN_valid  output  1  (N=0,1) response for requester N is valid.
REQ-009 respN_ready  input  1  (N=0,1) requester N consumes the response.
REQ-010 resp_result  output  32  result shared by both response channels.
REQ-011 resp_status  output  8  {zero, overflow, carry, negative, invalid_address, div_zero, 0, illegal_op}.
REQ-012 alu_control  output  4  drives the combinational ALU opcode.
REQ-013 alu_operand_1, alu_operand_2  output  32  drive the ALU operands.
REQ-014 alu_result  input  32  ALU result; alu_status  input  8  ALU status, bits [1:0] always 0.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-017 IDLE: grant computed combinationally from reqN_valid; reqN_ready = grant_N; at most one ready high; both ready low outside IDLE.
REQ-018 Arbitration FAIR=1: both valid -> grant to requester not granted last; pointer updates only on acceptance.
REQ-019 Arbitration FAIR=0: req0 wins whenever req0_valid.
REQ-020 On acceptance: latch control, op1, op2, owner id; next state EXEC if opcode legal, else RESP.
REQ-021 EXEC (exactly 1 cycle): alu_control/operands = latched values; at end of cycle capture alu_result and {alu_status[7:2], 1'b0, 1'b0} into response registers; next state RESP.
REQ-022 Illegal opcode (not in REQ-006 list): ALU never driven with it; response result 32'h0, status 8'h01; no EXEC cycle.
REQ-023 RESP: resp<owner>_valid high, other respN_valid low; resp_result/resp_status stable until respN_ready sampled high; then IDLE.
REQ-024 Latency: accept at edge T -> legal op resp valid from cycle after edge T+1 (2 cycles); illegal op from cycle after T (1 cycle); minimum 3 cycles per legal transaction including IDLE.
REQ-025 reqN_valid deasserted while not granted: no effect; inputs ignored outside IDLE.
REQ-026 Outside EXEC: alu_control = 4'b0000, alu_operand_1 = alu_operand_2 = 0.
REQ-027 respN_ready high while respN_valid low: ignored.
REQ-028 Arithmetic: no width change; result and flags taken verbatim from ALU, no re-computation.

Reset
REQ-029 rst high at a rising edge: state IDLE, round-robin pointer favours req0, response registers 0, all respN_valid low, busy low.
REQ-030 rst during EXEC or RESP: transaction dropped, no response issued, no reqN_ready in that cycle.
REQ-031 rst has priority over every other event in the same cycle.

Verification
REQ-032 Single add: req0 add 32'h7FFFFFFF + 32'h1 -> resp0_valid 2 cycles after accept, result 32'h80000000, status overflow bit (bit 6) = 1, bit 0 = 0.
REQ-033 Contention FAIR=1: both valid continuously with sub 5-5 -> grants alternate 0,1,0,1; each response result 0, zero bit (bit 7) = 1.
REQ-034 Illegal op: req1 control 4'b0011 -> resp1_valid next cycle, result 32'h0, status 8'h01; alu_control stays 4'b0000 throughout.
REQ-035 Backpressure: resp0_ready held low 5 cycles -> resp0_valid, resp_result stable, req0_ready/req1_ready low, busy high until consumed.
REQ-036 Reset mid-op: rst asserted during EXEC -> next cycle IDLE, no respN_valid, next contention grants req0 first.
REQ-037 FAIR=0: both valid continuously -> req1 never granted while req0_valid high; granted first cycle req0_valid low.
